// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch PC sequencer with prefetch FIFO, valid/ready handoff and redirect flush
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_fetch_en,
  output logic [31:0]                   o_imem_addr,
  input  logic [31:0]                   i_imem_instr,
  input  logic                          i_redirect_valid,
  input  logic [31:0]                   i_redirect_pc,
  output logic                          o_if_valid,
  output logic [31:0]                   o_if_instr,
  output logic [31:0]                   o_if_pc,
  input  logic                          i_if_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_misaligned
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] mem_pc [FIFO_DEPTH];
  logic [31:0] mem_instr [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic redir, bad, push, pop;
  assign redir = i_redirect_valid & (state != ERROR);
  assign bad = redir & (i_redirect_pc[1:0] != 2'b00);
  assign o_imem_addr = fetch_pc;
  assign o_fifo_count = count;
  assign o_if_valid = (count != '0) & ~i_redirect_valid & (state != ERROR);
  assign o_if_instr = o_if_valid ? mem_instr[head] : '0;
  assign o_if_pc = o_if_valid ? mem_pc[head] : '0;
  assign pop = o_if_valid & i_if_ready;
  assign push = (state == RUN) & i_fetch_en & ~i_redirect_valid & ((count < FULL) | pop);
  always_comb begin
    state_nxt = (state == ERROR || bad) ? ERROR : (i_fetch_en ? RUN : IDLE);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      count <= '0;
      o_misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redir) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        fetch_pc <= bad ? fetch_pc : i_redirect_pc;
        o_misaligned <= o_misaligned | bad;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (push) fetch_pc <= fetch_pc + 32'd4;
        if (pop) head <= head + AW'(1);
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end
  // storage needs no reset: occupancy alone decides what is visible
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_pc[tail] <= fetch_pc;
      mem_instr[tail] <= i_imem_instr;
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: randomized and directed checks against a queue-based fetch model
module tb_instr_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n, en, rdy, rv;
  logic [31:0] rpc, imem_addr, imem_instr, if_instr, if_pc;
  logic if_valid, mis;
  logic [2:0] cnt;
  int total = 0;
  int passed = 0;

  instr_fetch_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fetch_en(en), .o_imem_addr(imem_addr),
    .i_imem_instr(imem_instr), .i_redirect_valid(rv), .i_redirect_pc(rpc),
    .o_if_valid(if_valid), .o_if_instr(if_instr), .o_if_pc(if_pc),
    .i_if_ready(rdy), .o_fifo_count(cnt), .o_misaligned(mis)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_instr = rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  logic [63:0] q[$];
  logic [31:0] m_pc;
  bit m_run, m_err;

  // model: queue of {pc,instr}, a fetch pointer and run/error flags
  always @(negedge clk) begin
    bit ev, pe, pu;
    logic [63:0] hd;
    if (!rst_n) begin
      q.delete();
      m_pc = 32'h0;
      m_run = 0;
      m_err = 0;
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_count", {29'b0, cnt}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_mis", {31'b0, mis}, 32'd0);
    end else begin
      ev = q.size() != 0 && !rv && !m_err;
      hd = ev ? q[0] : 64'h0;
      chk("valid", {31'b0, if_valid}, {31'b0, ev});
      chk("pc", if_pc, hd[63:32]);
      chk("instr", if_instr, hd[31:0]);
      chk("count", {29'b0, cnt}, q.size());
      chk("addr", imem_addr, m_pc);
      chk("mis", {31'b0, mis}, {31'b0, m_err});
      if (!m_err && rv) begin
        q.delete();
        if (rpc[1:0] != 2'b00) m_err = 1;
        else m_pc = rpc;
      end else begin
        pe = ev && rdy;
        pu = m_run && en && (q.size() < 4 || pe);
        if (pe) void'(q.pop_front());
        if (pu) begin
          q.push_back({m_pc, rom(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
      m_run = !m_err && en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, if_valid}, 32'd0);
    chk("async_count", {29'b0, cnt}, 32'd0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_mis", {31'b0, mis}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rdy = 1'b0; rv = 1'b0; rpc = 32'h0;
    step();
    step();
    rst_n = 1'b1;
    chk("init_addr", imem_addr, 32'h0);
    chk("init_count", {29'b0, cnt}, 32'd0);
    en = 1'b1; rdy = 1'b1;
    step();
    step();
    wait_neg();
    chk("first_valid", {31'b0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_instr", if_instr, rom(32'h0));
    for (int i = 1; i < 4; i++) begin
      step();
      chk("seq_pc", if_pc, 32'(i * 4));
    end
    do_reset();
    en = 1'b1; rdy = 1'b0;
    repeat (10) step();
    chk("sat_count", {29'b0, cnt}, 32'd4);
    chk("sat_addr", imem_addr, 32'h10);
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_neg();
      chk("drain_pc", if_pc, 32'(i * 4));
      chk("full_pop_count", {29'b0, cnt}, 32'd4);
      step();
    end
    en = 1'b0;
    step();
    chk("three_count", {29'b0, cnt}, 32'd3);
    en = 1'b1; rdy = 1'b0; rv = 1'b1; rpc = 32'h40;
    wait_neg();
    chk("redir_valid", {31'b0, if_valid}, 32'd0);
    step();
    rv = 1'b0;
    chk("redir_count", {29'b0, cnt}, 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    step();
    chk("target_valid", {31'b0, if_valid}, 32'd1);
    chk("target_pc", if_pc, 32'h40);
    en = 1'b0; rdy = 1'b1;
    repeat (3) step();
    chk("idle_addr", imem_addr, 32'h44);
    chk("idle_count", {29'b0, cnt}, 32'd0);
    en = 1'b1;
    step();
    step();
    chk("resume_pc", if_pc, 32'h44);
    rv = 1'b1; rpc = 32'h42;
    step();
    rv = 1'b0;
    chk("err_mis", {31'b0, mis}, 32'd1);
    chk("err_valid", {31'b0, if_valid}, 32'd0);
    chk("err_addr", imem_addr, 32'h48);
    rv = 1'b1; rpc = 32'h80;
    step();
    rv = 1'b0;
    step();
    chk("err_hold_mis", {31'b0, mis}, 32'd1);
    chk("err_hold_addr", imem_addr, 32'h48);
    chk("err_hold_count", {29'b0, cnt}, 32'd0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      en = ($urandom % 8) != 0;
      rdy = ($urandom % 3) != 0;
      rv = ($urandom % 12) == 0;
      r = $urandom % 64;
      if (r == 0) rpc = {$urandom, 2'b00} | 32'($urandom_range(1, 3));
      else if (r < 6) rpc = 32'hFFFF_FFF0;
      else rpc = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom % 200 == 0) do_reset();
      step();
    end
    rv = 1'b0;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
